// File: rtl/riscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu_pkg
// Description : Shared types and helpers for the load/store unit: access
//               size and FSM state encodings, byte-enable mask per size.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'b00,
        HALF   = 2'b01,
        WORD   = 2'b10,
        DOUBLE = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } lsu_state_e;

    // Right-justified byte-enable pattern for an access of the given size.
    function automatic logic [7:0] lsu_be_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            BYTE:    mask = 8'h01;
            HALF:    mask = 8'h03;
            WORD:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_ext.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ext
// Description : Sign- or zero-extension of a narrow value to a wider word.
//               Equal widths pass the value through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_ext #(
    parameter int DATA_WIDTH_I = 8,
    parameter int DATA_WIDTH_O = 32,
    parameter bit SIGNED       = 1'b0
) (
    input  logic [DATA_WIDTH_I-1:0] i_data,
    output logic [DATA_WIDTH_O-1:0] o_data
);

    generate
        if (DATA_WIDTH_O == DATA_WIDTH_I) begin : g_pass
            assign o_data = i_data;
        end else if (SIGNED) begin : g_sext
            assign o_data = {{(DATA_WIDTH_O-DATA_WIDTH_I){i_data[DATA_WIDTH_I-1]}}, i_data};
        end else begin : g_zext
            assign o_data = {{(DATA_WIDTH_O-DATA_WIDTH_I){1'b0}}, i_data};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu
// Description : Single-outstanding load/store unit. Checks alignment, runs a
//               req/gnt/rvalid bus transaction with byte enables and lane-
//               shifted store data, returns extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic [4:0]        rsp_rd_o,
    output logic              rsp_err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int c_BEW  = XLEN / 8;
    localparam int c_OFFW = $clog2(c_BEW);

    localparam logic [1:0] c_ST_IDLE = 2'(IDLE);
    localparam logic [1:0] c_ST_REQ  = 2'(REQ);
    localparam logic [1:0] c_ST_WAIT = 2'(WAIT);
    localparam logic [1:0] c_ST_RSP  = 2'(RSP);

    logic [1:0]      r_state;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [c_OFFW-1:0] r_off;

    logic [c_OFFW-1:0] w_off;
    logic              w_err;
    logic [c_BEW-1:0]  w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_addr;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_s8, w_u8, w_s16, w_u16, w_s32, w_u32;

    assign w_off     = req_addr_i[c_OFFW-1:0];
    assign w_be      = c_BEW'(lsu_be_mask(req_size_i)) << w_off;
    assign w_wdata   = req_wdata_i << {w_off, 3'b000};
    assign w_addr    = {req_addr_i[XLEN-1:c_OFFW], {c_OFFW{1'b0}}};
    assign w_shifted = mem_rdata_i >> {r_off, 3'b000};

    assign req_ready_o = (r_state == c_ST_IDLE);
    assign mem_req_o   = (r_state == c_ST_REQ);
    assign rsp_valid_o = (r_state == c_ST_RSP);

    // Misalignment / illegal-size detection on the incoming request.
    always_comb begin
        w_err = 1'b0;
        case (req_size_i)
            BYTE:    w_err = 1'b0;
            HALF:    w_err = req_addr_i[0];
            WORD:    w_err = |req_addr_i[1:0];
            default: w_err = (XLEN == 32) ? 1'b1 : |req_addr_i[2:0];
        endcase
    end

    riscv_ext #(.DATA_WIDTH_I(8),  .DATA_WIDTH_O(XLEN), .SIGNED(1'b1)) u_ext_s8  (.i_data(w_shifted[7:0]),  .o_data(w_s8));
    riscv_ext #(.DATA_WIDTH_I(8),  .DATA_WIDTH_O(XLEN), .SIGNED(1'b0)) u_ext_u8  (.i_data(w_shifted[7:0]),  .o_data(w_u8));
    riscv_ext #(.DATA_WIDTH_I(16), .DATA_WIDTH_O(XLEN), .SIGNED(1'b1)) u_ext_s16 (.i_data(w_shifted[15:0]), .o_data(w_s16));
    riscv_ext #(.DATA_WIDTH_I(16), .DATA_WIDTH_O(XLEN), .SIGNED(1'b0)) u_ext_u16 (.i_data(w_shifted[15:0]), .o_data(w_u16));
    riscv_ext #(.DATA_WIDTH_I(32), .DATA_WIDTH_O(XLEN), .SIGNED(1'b1)) u_ext_s32 (.i_data(w_shifted[31:0]), .o_data(w_s32));
    riscv_ext #(.DATA_WIDTH_I(32), .DATA_WIDTH_O(XLEN), .SIGNED(1'b0)) u_ext_u32 (.i_data(w_shifted[31:0]), .o_data(w_u32));

    // Select the extended load value by captured size and signedness.
    always_comb begin
        w_load = w_shifted;
        case (r_size)
            BYTE:    w_load = r_unsigned ? w_u8  : w_s8;
            HALF:    w_load = r_unsigned ? w_u16 : w_s16;
            WORD:    w_load = r_unsigned ? w_u32 : w_s32;
            default: w_load = w_shifted;
        endcase
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rsp_rdata_o <= '0;
            rsp_rd_o    <= 5'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid_i) begin
                        r_we        <= req_we_i;
                        r_size      <= req_size_i;
                        r_unsigned  <= req_unsigned_i;
                        r_off       <= w_off;
                        rsp_rd_o    <= req_rd_i;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= w_err;
                        if (w_err) begin
                            r_state <= c_ST_RSP;
                        end else begin
                            r_state     <= c_ST_REQ;
                            mem_we_o    <= req_we_i;
                            mem_be_o    <= w_be;
                            mem_addr_o  <= w_addr;
                            mem_wdata_o <= w_wdata;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (mem_gnt_i) begin
                        r_state     <= c_ST_WAIT;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= '0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                    end
                end
                c_ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_state     <= c_ST_RSP;
                        rsp_rdata_o <= r_we ? '0 : w_load;
                    end
                end
                default: begin
                    if (rsp_ready_i) begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
